xy_sample_writer: RTL and testbench
===================================

# xy_sample_writer

Fills the two-bank X/Y sample RAM that the XY curve renderer reads during each frame. It accepts paired signed samples (X channel 1, Y channel 2) and optionally decimates them. It writes a full record of `SAMPLE_COUNT` pairs into the back bank, then swaps banks at the renderer's frame-start pulse so the display never reads a half-written record. It sits between the ADC sample path and the sample RAM write ports; the renderer's read address is formed at top level as `{readBank, address}`.

## Interface

- `DATA_IN_BITS`, 12, sample width (signed, two's complement)
- `ADDRESS_BITS`, 12, full RAM address width; the MSB is the bank select
- `SAMPLE_COUNT`, 1024, pairs per record; must be ≤ 2^(ADDRESS_BITS-1)
- `DECIMATION_BITS`, 8, width of the decimation input

- `clock` in 1: single clock; all logic on posedge.
- `reset` in 1: synchronous, active-high.
- `sampleValid` in 1: one-cycle strobe marking a new pair.
- `sampleIn1` in DATA_IN_BITS: signed X sample.
- `sampleIn2` in DATA_IN_BITS: signed Y sample.
- `decimation` in DECIMATION_BITS: keep one of every `decimation+1` valid pairs.
- `triggerLevel` in DATA_IN_BITS: signed trigger threshold on channel 1; ignored unless the trigger macro is defined.
- `drawStarting` in 1: renderer frame-start pulse, one cycle.
- `writeEnable` out 1: RAM write strobe.
- `writeAddress` out ADDRESS_BITS: `{backBank, index}`, where `backBank = ~readBank`.
- `writeData1` out DATA_IN_BITS: X sample to RAM.
- `writeData2` out DATA_IN_BITS: Y sample to RAM.
- `readBank` out 1: bank the renderer must read.
- `captureDone` out 1: high while the back bank holds a complete record awaiting swap.
- `missedFrame` out 1: one-cycle pulse when `drawStarting` arrives before the record is complete.

## Operation

- **Decimation counter:** increments on each `sampleValid`. A pair is *accepted* when the counter equals `decimation`; the counter then clears to 0. With `decimation = 0`, every valid pair is accepted. A `decimation` change takes effect on the next compare; if the counter already exceeds the new value, it clears on the next valid pair without accepting it.
- **FILL state:**
  - Each accepted pair is written to `{~readBank, index}`, then `index` increments.
  - On the accept with `index == SAMPLE_COUNT-1`: write it, clear `index` to 0, go to FULL.
- **FULL state:**
  - Accepted pairs are discarded; the decimation counter keeps running.
  - On `drawStarting`: toggle `readBank`, then go to FILL, or to ARM if `XY_TRIGGER_EN` is defined.
- **`drawStarting` in FILL or ARM:** no swap; pulse `missedFrame`. The renderer redraws the old front bank.
- **Simultaneous final accept and `drawStarting`:** treated as missed. Pulse `missedFrame`, go to FULL with no swap; the swap happens at the next `drawStarting`.
- **Address width:** `index` is ADDRESS_BITS-1 wide. It never wraps past `SAMPLE_COUNT-1`.
- **Write data:** passes through unmodified; no clipping or offset. Screen centering is done by the reader.

## Timing

- **Write latency:** `writeEnable`, `writeAddress` and `writeData*` are registered. They are valid the cycle after the accepting `sampleValid` edge, for exactly one cycle.
- **Back-to-back accepts:** `sampleValid` on consecutive cycles with `decimation = 0` yields one write per cycle.
- **Last write vs. swap:** the final record write is issued before any swap it enables. The earliest swap is the `drawStarting` one or more cycles after the final accept.
- **Swap latency:** `readBank` toggles the cycle after the `drawStarting` edge. `captureDone` falls in that same cycle.
- **`captureDone`:** rises the cycle after the final accept.
- **`missedFrame`:** registered; high the cycle after the offending `drawStarting`.
- **Reset values:** `readBank` = 0, `index` = 0, decimation counter = 0, `writeEnable` = 0, `writeAddress` = 0, `writeData1`/`writeData2` = 0, `captureDone` = 0, `missedFrame` = 0. The state after reset is FILL, or ARM with the trigger macro.
- **Reset mid-record:** abandons the partial record. The back-bank contents are stale, but the next record overwrites every address before `captureDone`.

## Configuration

- `XY_TRIGGER_EN` defined:
  - Adds the ARM state, entered after reset and after every swap.
  - ARM tracks the previous accepted `sampleIn1`, and discards accepted pairs until a rising crossing: previous < `triggerLevel` ≤ current, signed compare.
  - The crossing pair is written at index 0, then the state is FILL.
  - The first accepted pair in ARM only loads the previous value.
- `XY_TRIGGER_EN` undefined:
  - No ARM state; FILL begins immediately.
  - `triggerLevel` is unused.

## Test plan

- **Basic record, no trigger:** reset, `decimation` = 0, 1024 consecutive valid pairs X = i, Y = -i → writes to addresses 0x800+i with matching data; `captureDone` rises one cycle after the 1024th accept; `readBank` stays 0.
- **Swap:** after `captureDone`, pulse `drawStarting` → `readBank` = 1 next cycle, `captureDone` = 0; the next record writes addresses 0x000–0x3FF.
- **Missed frame and simultaneous event:**
  - `drawStarting` at accepted pair 500 → `missedFrame` pulse, no swap.
  - `drawStarting` coincident with the 1024th accept → `missedFrame` pulse, no swap, `captureDone` = 1.
- **Decimation:** `decimation` = 3, 4096 valid pairs → exactly 1024 writes, taken from valid pairs 3, 7, 11, …; writes are spaced 4 strobes apart.
- **Trigger (`XY_TRIGGER_EN` defined):** `triggerLevel` = 100, ramp -200 → 300 in steps of 50 → first write at index 0 is X = 100; all earlier pairs are discarded.
- **Reset mid-record:** reset after 300 accepts → all outputs at reset values next cycle; the next write goes to 0x800 (index 0).

Source files
------------

// File: rtl/xy_sample_writer.sv
// Double-buffered X/Y sample RAM writer: decimates paired samples, fills the back bank
// and swaps banks on the renderer's frame-start pulse. Optional trigger arming: XY_TRIGGER_EN.
module xy_sample_writer #(
    parameter int DATA_IN_BITS    = 12,
    parameter int ADDRESS_BITS    = 12,
    parameter int SAMPLE_COUNT    = 1024,
    parameter int DECIMATION_BITS = 8
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       sampleValid,
    input  logic [DATA_IN_BITS-1:0]    sampleIn1,
    input  logic [DATA_IN_BITS-1:0]    sampleIn2,
    input  logic [DECIMATION_BITS-1:0] decimation,
    input  logic [DATA_IN_BITS-1:0]    triggerLevel,
    input  logic                       drawStarting,
    output logic                       writeEnable,
    output logic [ADDRESS_BITS-1:0]    writeAddress,
    output logic [DATA_IN_BITS-1:0]    writeData1,
    output logic [DATA_IN_BITS-1:0]    writeData2,
    output logic                       readBank,
    output logic                       captureDone,
    output logic                       missedFrame
);

    localparam int INDEX_BITS = ADDRESS_BITS - 1;
    localparam logic [INDEX_BITS-1:0] LAST_INDEX = INDEX_BITS'(SAMPLE_COUNT - 1);

    typedef enum logic [1:0] {
        FILL = 2'd0,
        FULL = 2'd1
`ifdef XY_TRIGGER_EN
        , ARM = 2'd2
`endif
    } stateT;

    stateT                      stateReg, stateNext;
    logic [INDEX_BITS-1:0]      indexReg, indexNext;
    logic [DECIMATION_BITS-1:0] decimCountReg, decimCountNext;
    logic                       readBankReg, readBankNext;
    logic                       captureDoneReg, captureDoneNext;
    logic                       missedFrameReg, missedFrameNext;
    logic                       writeEnableReg, writeEnableNext;
    logic [ADDRESS_BITS-1:0]    writeAddressReg, writeAddressNext;
    logic [DATA_IN_BITS-1:0]    writeData1Reg, writeData1Next;
    logic [DATA_IN_BITS-1:0]    writeData2Reg, writeData2Next;
    logic                       acceptPair;
    logic                       doWrite;

`ifdef XY_TRIGGER_EN
    logic [DATA_IN_BITS-1:0]    prevSampleReg, prevSampleNext;
    logic                       prevValidReg, prevValidNext;
    localparam stateT RESET_STATE = ARM;
    localparam stateT SWAP_STATE  = ARM;
`else
    logic unusedTriggerLevel;
    assign unusedTriggerLevel = ^triggerLevel;
    localparam stateT RESET_STATE = FILL;
    localparam stateT SWAP_STATE  = FILL;
`endif

    // A counter left above a newly lowered decimation clears without accepting.
    always_comb begin
        acceptPair     = 1'b0;
        decimCountNext = decimCountReg;
        if (sampleValid) begin
            if (decimCountReg == decimation) begin
                acceptPair     = 1'b1;
                decimCountNext = '0;
            end else if (decimCountReg > decimation) begin
                decimCountNext = '0;
            end else begin
                decimCountNext = decimCountReg + DECIMATION_BITS'(1);
            end
        end
    end

    always_comb begin
        stateNext        = stateReg;
        indexNext        = indexReg;
        readBankNext     = readBankReg;
        captureDoneNext  = captureDoneReg;
        missedFrameNext  = 1'b0;
        writeEnableNext  = 1'b0;
        writeAddressNext = writeAddressReg;
        writeData1Next   = writeData1Reg;
        writeData2Next   = writeData2Reg;
        doWrite          = 1'b0;
`ifdef XY_TRIGGER_EN
        prevSampleNext   = prevSampleReg;
        prevValidNext    = prevValidReg;
`endif
        case (stateReg)
            FILL: begin
                doWrite = acceptPair;
                if (drawStarting) missedFrameNext = 1'b1;
            end
            FULL: begin
                if (drawStarting) begin
                    readBankNext    = ~readBankReg;
                    captureDoneNext = 1'b0;
                    stateNext       = SWAP_STATE;
`ifdef XY_TRIGGER_EN
                    prevValidNext   = 1'b0;
`endif
                end
            end
`ifdef XY_TRIGGER_EN
            ARM: begin
                if (drawStarting) missedFrameNext = 1'b1;
                if (acceptPair) begin
                    if (prevValidReg &&
                        ($signed(prevSampleReg) < $signed(triggerLevel)) &&
                        ($signed(triggerLevel) <= $signed(sampleIn1))) begin
                        doWrite   = 1'b1;
                        stateNext = FILL;
                    end
                    prevSampleNext = sampleIn1;
                    prevValidNext  = 1'b1;
                end
            end
`endif
            default: stateNext = RESET_STATE;
        endcase

        // Final write of a record lands in the back bank before any swap it enables.
        if (doWrite) begin
            writeEnableNext  = 1'b1;
            writeAddressNext = {~readBankReg, indexReg};
            writeData1Next   = sampleIn1;
            writeData2Next   = sampleIn2;
            if (indexReg == LAST_INDEX) begin
                indexNext       = '0;
                stateNext       = FULL;
                captureDoneNext = 1'b1;
            end else begin
                indexNext = indexReg + INDEX_BITS'(1);
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            stateReg        <= RESET_STATE;
            indexReg        <= '0;
            decimCountReg   <= '0;
            readBankReg     <= 1'b0;
            captureDoneReg  <= 1'b0;
            missedFrameReg  <= 1'b0;
            writeEnableReg  <= 1'b0;
            writeAddressReg <= '0;
            writeData1Reg   <= '0;
            writeData2Reg   <= '0;
`ifdef XY_TRIGGER_EN
            prevSampleReg   <= '0;
            prevValidReg    <= 1'b0;
`endif
        end else begin
            stateReg        <= stateNext;
            indexReg        <= indexNext;
            decimCountReg   <= decimCountNext;
            readBankReg     <= readBankNext;
            captureDoneReg  <= captureDoneNext;
            missedFrameReg  <= missedFrameNext;
            writeEnableReg  <= writeEnableNext;
            writeAddressReg <= writeAddressNext;
            writeData1Reg   <= writeData1Next;
            writeData2Reg   <= writeData2Next;
`ifdef XY_TRIGGER_EN
            prevSampleReg   <= prevSampleNext;
            prevValidReg    <= prevValidNext;
`endif
        end
    end

    assign writeEnable  = writeEnableReg;
    assign writeAddress = writeAddressReg;
    assign writeData1   = writeData1Reg;
    assign writeData2   = writeData2Reg;
    assign readBank     = readBankReg;
    assign captureDone  = captureDoneReg;
    assign missedFrame  = missedFrameReg;

endmodule

// File: tb/tb_xy_sample_writer.sv
// Scoreboard bench for xy_sample_writer (default build): stimulus queues expected RAM
// writes, a negedge monitor pops and compares each presented write.
module tb_xy_sample_writer;

    logic        clock;
    logic        reset;
    logic        sampleValid;
    logic [11:0] sampleIn1;
    logic [11:0] sampleIn2;
    logic [7:0]  decimation;
    logic [11:0] triggerLevel;
    logic        drawStarting;
    logic        writeEnable;
    logic [11:0] writeAddress;
    logic [11:0] writeData1;
    logic [11:0] writeData2;
    logic        readBank;
    logic        captureDone;
    logic        missedFrame;

    int checkCount = 0;
    int errorCount = 0;
    int writesSeen = 0;
    logic [35:0] expQ[$];

    xy_sample_writer dut (
        .clock        (clock),
        .reset        (reset),
        .sampleValid  (sampleValid),
        .sampleIn1    (sampleIn1),
        .sampleIn2    (sampleIn2),
        .decimation   (decimation),
        .triggerLevel (triggerLevel),
        .drawStarting (drawStarting),
        .writeEnable  (writeEnable),
        .writeAddress (writeAddress),
        .writeData1   (writeData1),
        .writeData2   (writeData2),
        .readBank     (readBank),
        .captureDone  (captureDone),
        .missedFrame  (missedFrame)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #1000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checkCount++;
        if (act !== exp) begin
            errorCount++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Write monitor / scoreboard
    always @(negedge clock) begin
        if (writeEnable === 1'b1) begin
            writesSeen++;
            checkCount++;
            $display("write addr=%h d1=%h d2=%h", writeAddress, writeData1, writeData2);
            if (expQ.size() == 0) begin
                errorCount++;
                $display("FAIL unexpected_write actual=%h required=none", writeAddress);
            end else begin
                logic [35:0] e;
                e = expQ.pop_front();
                if ({writeAddress, writeData1, writeData2} !== e) begin
                    errorCount++;
                    $display("FAIL write actual=%h/%h/%h required=%h/%h/%h",
                             writeAddress, writeData1, writeData2, e[35:24], e[23:12], e[11:0]);
                end
            end
        end
    end

    task automatic sendPair(input logic [11:0] x, input logic [11:0] y, input bit expWr,
                            input logic [11:0] addr, input bit draw);
        sampleValid  = 1'b1;
        sampleIn1    = x;
        sampleIn2    = y;
        drawStarting = draw;
        if (expWr) expQ.push_back({addr, x, y});
        @(posedge clock);
        #1;
        sampleValid  = 1'b0;
        drawStarting = 1'b0;
    endtask

    task automatic pulseDraw();
        drawStarting = 1'b1;
        @(posedge clock);
        #1;
        drawStarting = 1'b0;
    endtask

    task automatic checkResetValues(input string tag);
        check({tag, "_readBank"}, 32'(readBank), 32'd0);
        check({tag, "_writeEnable"}, 32'(writeEnable), 32'd0);
        check({tag, "_writeAddress"}, 32'(writeAddress), 32'd0);
        check({tag, "_writeData1"}, 32'(writeData1), 32'd0);
        check({tag, "_writeData2"}, 32'(writeData2), 32'd0);
        check({tag, "_captureDone"}, 32'(captureDone), 32'd0);
        check({tag, "_missedFrame"}, 32'(missedFrame), 32'd0);
    endtask

    initial begin
        int startWrites;
        reset        = 1'b1;
        sampleValid  = 1'b0;
        sampleIn1    = '0;
        sampleIn2    = '0;
        decimation   = '0;
        triggerLevel = 12'd100;
        drawStarting = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        checkResetValues("reset");
        reset = 1'b0;

        // Record 1 into bank 1 (readBank = 0)
        for (int i = 0; i < 1024; i++) begin
            sendPair(12'(i), 12'(-i), 1'b1, 12'(32'h800 + i), 1'b0);
            if (i == 1022) check("captureDone_before_last", 32'(captureDone), 32'd0);
        end
        check("captureDone_after_last", 32'(captureDone), 32'd1);
        check("readBank_rec1", 32'(readBank), 32'd0);

        // Accepted pairs while FULL are discarded
        for (int i = 0; i < 3; i++) sendPair(12'h123, 12'h456, 1'b0, 12'h0, 1'b0);
        check("captureDone_full_hold", 32'(captureDone), 32'd1);

        pulseDraw();
        check("swap1_readBank", 32'(readBank), 32'd1);
        check("swap1_captureDone", 32'(captureDone), 32'd0);
        check("swap1_missedFrame", 32'(missedFrame), 32'd0);

        // Record 2 into bank 0 with missed frames at pair 500 and at the final pair
        for (int i = 0; i < 1024; i++) begin
            sendPair(12'(i * 3), 12'(i + 7), 1'b1, 12'(i), (i == 500) || (i == 1023));
            if (i == 500) begin
                check("missed500_pulse", 32'(missedFrame), 32'd1);
                check("missed500_readBank", 32'(readBank), 32'd1);
            end
            if (i == 501) check("missed500_clear", 32'(missedFrame), 32'd0);
        end
        check("missedLast_pulse", 32'(missedFrame), 32'd1);
        check("missedLast_captureDone", 32'(captureDone), 32'd1);
        check("missedLast_readBank", 32'(readBank), 32'd1);
        @(posedge clock);
        #1;
        check("missedLast_clear", 32'(missedFrame), 32'd0);
        check("missedLast_noSwap", 32'(readBank), 32'd1);

        pulseDraw();
        check("swap2_readBank", 32'(readBank), 32'd0);
        check("swap2_captureDone", 32'(captureDone), 32'd0);

        // Decimation by 4: pairs 3, 7, 11, ... land at 0x800 + i/4
        decimation  = 8'd3;
        startWrites = writesSeen;
        for (int i = 0; i < 4096; i++)
            sendPair(12'(i), 12'(~i), (i % 4) == 3, 12'(32'h800 + i / 4), 1'b0);
        @(negedge clock);
        #1;
        check("decim_writeCount", 32'(writesSeen - startWrites), 32'd1024);
        check("decim_captureDone", 32'(captureDone), 32'd1);

        pulseDraw();
        check("swap3_readBank", 32'(readBank), 32'd1);

        // Reset in the middle of a record
        decimation = 8'd0;
        for (int i = 0; i < 300; i++)
            sendPair(12'(i + 5), 12'(i), 1'b1, 12'(i), 1'b0);
        check("midrec_captureDone", 32'(captureDone), 32'd0);
        reset = 1'b1;
        @(posedge clock);
        #1;
        checkResetValues("midReset");
        reset = 1'b0;
        sendPair(12'd7, 12'd8, 1'b1, 12'h800, 1'b0);

        // Lowering decimation below the running count clears without accepting
        decimation = 8'd3;
        sendPair(12'd1, 12'd1, 1'b0, 12'h0, 1'b0);
        sendPair(12'd2, 12'd2, 1'b0, 12'h0, 1'b0);
        decimation = 8'd1;
        sendPair(12'd3, 12'd3, 1'b0, 12'h0, 1'b0);
        sendPair(12'd4, 12'd4, 1'b0, 12'h0, 1'b0);
        sendPair(12'd9, 12'd10, 1'b1, 12'h801, 1'b0);

        repeat (3) @(posedge clock);
        #1;
        check("scoreboard_empty", 32'(expQ.size()), 32'd0);
        check("total_writes", 32'(writesSeen), 32'(1024 + 1024 + 1024 + 300 + 2));

        $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
        $finish;
    end

endmodule
